// File: rtl/seg_anim_seq_pkg.sv
// Shared mode encoding, per-mode step lengths and segment bit positions
// for the seven-segment animation sequencer.
package seg_anim_seq_pkg;

  typedef enum logic [2:0] {
    MODE_DIGIT  = 3'd0,
    MODE_CHASE  = 3'd1,
    MODE_RCHASE = 3'd2,
    MODE_FILL   = 3'd3,
    MODE_PAIR   = 3'd4,
    MODE_BLINK  = 3'd5
  } mode_e;

  localparam int NUM_MODES = 6;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_RESET = 7'h3F;

  // Last valid step index of each mode; the step counter runs 0..len inclusive.
  function automatic logic [3:0] mode_len(input mode_e m);
    case (m)
      MODE_DIGIT:                        mode_len = 4'd9;
      MODE_CHASE, MODE_RCHASE, MODE_FILL: mode_len = 4'd6;
      MODE_PAIR, MODE_BLINK:             mode_len = 4'd5;
      default:                           mode_len = 4'd0;
    endcase
  endfunction

  function automatic mode_e clamp_mode(input logic [2:0] sel);
    clamp_mode = (sel > 3'd5) ? MODE_DIGIT : mode_e'(sel);
  endfunction

endpackage

// File: rtl/seg_pattern_rom.sv
// Combinational pattern table: (mode, step index) -> segments a..g.
// Indices past a mode's last entry read as blank.
module seg_pattern_rom
  import seg_anim_seq_pkg::*;
(
  input  mode_e       mode,
  input  logic [3:0]  idx,
  output logic [6:0]  seg
);

  always_comb begin
    seg = 7'h00;
    case (mode)
      MODE_DIGIT: begin
        case (idx)
          4'd0: seg = 7'h3F;
          4'd1: seg = 7'h06;
          4'd2: seg = 7'h5B;
          4'd3: seg = 7'h4F;
          4'd4: seg = 7'h66;
          4'd5: seg = 7'h6D;
          4'd6: seg = 7'h7D;
          4'd7: seg = 7'h07;
          4'd8: seg = 7'h7F;
          4'd9: seg = 7'h6F;
          default: seg = 7'h00;
        endcase
      end
      MODE_CHASE: begin
        if (idx <= 4'd6) seg = 7'(7'h01 << idx);
      end
      MODE_RCHASE: begin
        if (idx <= 4'd6) seg = 7'(7'h40 >> idx);
      end
      MODE_FILL: begin
        if (idx <= 4'd6) seg = 7'(~(7'h7E << idx));
      end
      MODE_PAIR: begin
        case (idx)
          4'd0: seg = 7'h03;
          4'd1: seg = 7'h06;
          4'd2: seg = 7'h0C;
          4'd3: seg = 7'h18;
          4'd4: seg = 7'h30;
          4'd5: seg = 7'h21;
          default: seg = 7'h00;
        endcase
      end
      MODE_BLINK: begin
        // Even steps fully lit, odd steps dark.
        if (idx <= 4'd5) seg = idx[0] ? 7'h00 : 7'h7F;
      end
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg_anim_seq.sv
// Seven-segment animation sequencer: programmable prescaler, step/loop/mode
// state with auto rotation or manual select, pause/single-step, enable freeze.
module seg_anim_seq
  import seg_anim_seq_pkg::*;
#(
  parameter int CNT_W          = 24,
  parameter int MAX_COUNT      = 10_000_000,
  parameter int LOOPS_PER_MODE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       cfg_div,
  input  logic             auto_mode,
  input  logic [2:0]       mode_sel,
  input  logic             pause,
  input  logic             step,
  output logic [6:0]       seg_out,
  output logic             dp_out,
  output logic             tick_out,
  output logic [2:0]       mode_out,
  output logic [3:0]       step_out
);

  localparam int LOOP_W = (LOOPS_PER_MODE > 1) ? $clog2(LOOPS_PER_MODE) : 1;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cmp;
  logic [3:0]        step_idx;
  logic [LOOP_W-1:0] loop;
  mode_e             mode;
  mode_e             sel_mode;
  mode_e             next_mode;
  logic              step_q;
  logic              wrap;
  logic              step_rise;
  logic              adv;
  logic              man_req;
  logic              loop_last;
  logic [6:0]        pat;

  always_comb begin
    cmp       = (cfg_div == 8'd0) ? CNT_W'(MAX_COUNT) : CNT_W'({cfg_div, 10'b0});
    wrap      = (cnt == cmp);
    step_rise = step & ~step_q;
    // Ticks only drive stepping while running; a paused sequencer moves on step edges.
    adv       = pause ? step_rise : wrap;
    sel_mode  = clamp_mode(mode_sel);
    man_req   = ~auto_mode && (sel_mode != mode);
    loop_last = (loop == LOOP_W'(LOOPS_PER_MODE - 1));
    next_mode = (mode == MODE_BLINK) ? MODE_DIGIT : mode_e'(mode + 3'd1);
  end

  seg_pattern_rom u_rom (
    .mode (mode),
    .idx  (step_idx),
    .seg  (pat)
  );

  // The edge detector keeps sampling while frozen so a press held across ena
  // low is not seen as a fresh edge on resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      step_idx <= '0;
      loop     <= '0;
      mode     <= MODE_DIGIT;
      seg_out  <= SEG_RESET;
      dp_out   <= 1'b0;
      tick_out <= 1'b0;
      mode_out <= '0;
      step_out <= '0;
    end else if (ena) begin
      tick_out <= wrap;
      dp_out   <= pause;
      seg_out  <= pat;
      mode_out <= mode;
      step_out <= step_idx;
      if (man_req) begin
        mode     <= sel_mode;
        step_idx <= '0;
        loop     <= '0;
        cnt      <= '0;
      end else begin
        // >= also recovers when the compare value drops below the running count.
        cnt <= (cnt >= cmp) ? '0 : cnt + 1'b1;
        if (adv) begin
          if (step_idx == mode_len(mode)) begin
            step_idx <= '0;
            if (loop_last) begin
              loop <= '0;
              if (auto_mode) mode <= next_mode;
            end else begin
              loop <= loop + 1'b1;
            end
          end else begin
            step_idx <= step_idx + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_anim_seq.sv
// Scoreboard bench for seg_anim_seq: a cycle-level reference model queues the
// expected outputs, a negedge monitor pops and compares them.
module tb_seg_anim_seq;

  localparam int MAXC = 3;
  localparam int LPM  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] cfg_div = 8'd0;
  logic       auto_mode = 1'b1;
  logic [2:0] mode_sel = 3'd0;
  logic       pause = 1'b0;
  logic       step = 1'b0;
  logic [6:0] seg_out;
  logic       dp_out;
  logic       tick_out;
  logic [2:0] mode_out;
  logic [3:0] step_out;

  seg_anim_seq #(.CNT_W(24), .MAX_COUNT(MAXC), .LOOPS_PER_MODE(LPM)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_div(cfg_div),
    .auto_mode(auto_mode), .mode_sel(mode_sel), .pause(pause), .step(step),
    .seg_out(seg_out), .dp_out(dp_out), .tick_out(tick_out),
    .mode_out(mode_out), .step_out(step_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic       tick;
    logic [2:0] mode;
    logic [3:0] stp;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // Reference patterns written out from the display table.
  int lens[6] = '{9, 6, 6, 6, 5, 5};
  int pat[6][10] = '{
    '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F},
    '{'h01, 'h02, 'h04, 'h08, 'h10, 'h20, 'h40, 0, 0, 0},
    '{'h40, 'h20, 'h10, 'h08, 'h04, 'h02, 'h01, 0, 0, 0},
    '{'h01, 'h03, 'h07, 'h0F, 'h1F, 'h3F, 'h7F, 0, 0, 0},
    '{'h03, 'h06, 'h0C, 'h18, 'h30, 'h21, 0, 0, 0, 0},
    '{'h7F, 'h00, 'h7F, 'h00, 'h7F, 'h00, 0, 0, 0, 0}
  };

  int m_cnt, m_step, m_loop, m_mode, m_prev;

  function automatic exp_t reset_exp();
    exp_t e;
    e.seg = 7'h3F; e.dp = 1'b0; e.tick = 1'b0; e.mode = 3'd0; e.stp = 4'd0;
    return e;
  endfunction

  // Reference model: one update per clock, expected outputs queued for the monitor.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_step = 0; m_loop = 0; m_mode = 0; m_prev = 0;
      last_exp = reset_exp();
      exp_q.delete();
      exp_q.push_back(last_exp);
    end else begin
      int cmpv, sel;
      bit rise, wrapped, adv;
      cmpv = (cfg_div == 0) ? MAXC : int'(cfg_div) * 1024;
      rise = step && !m_prev;
      m_prev = step;
      if (ena) begin
        wrapped = (m_cnt == cmpv);
        last_exp.seg  = 7'(pat[m_mode][m_step]);
        last_exp.dp   = pause;
        last_exp.tick = wrapped;
        last_exp.mode = 3'(m_mode);
        last_exp.stp  = 4'(m_step);
        adv = pause ? rise : wrapped;
        sel = (mode_sel > 5) ? 0 : int'(mode_sel);
        if (!auto_mode && sel != m_mode) begin
          m_mode = sel; m_step = 0; m_loop = 0; m_cnt = 0;
        end else begin
          m_cnt = (m_cnt >= cmpv) ? 0 : m_cnt + 1;
          if (adv) begin
            if (m_step == lens[m_mode]) begin
              m_step = 0;
              m_loop = (m_loop + 1) % LPM;
              if (m_loop == 0 && auto_mode) m_mode = (m_mode + 1) % 6;
            end else begin
              m_step = m_step + 1;
            end
          end
        end
      end
      exp_q.push_back(last_exp);
    end
  end

  // Monitor: compares DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (seg_out !== e.seg || dp_out !== e.dp || tick_out !== e.tick ||
          mode_out !== e.mode || step_out !== e.stp) begin
        n_bad++;
        $display("FAIL outputs cyc=%0d got seg=%h dp=%b tick=%b mode=%0d step=%0d want seg=%h dp=%b tick=%b mode=%0d step=%0d",
                 cyc, seg_out, dp_out, tick_out, mode_out, step_out,
                 e.seg, e.dp, e.tick, e.mode, e.stp);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_step();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    run(3);
  endtask

  initial begin
    run(3);
    rst_n = 1'b1;

    // Auto rotation through every mode at the short prescaler period.
    run(400);

    // Asynchronous reset mid-count: outputs must clear before the next edge.
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (seg_out !== 7'h3F || dp_out !== 1'b0 || tick_out !== 1'b0 ||
        mode_out !== 3'd0 || step_out !== 4'd0) begin
      n_bad++;
      $display("FAIL async_reset got seg=%h dp=%b tick=%b mode=%0d step=%0d want seg=3f rest 0",
               seg_out, dp_out, tick_out, mode_out, step_out);
    end
    run(2);
    rst_n = 1'b1;
    run(30);

    // Manual selection, including the out-of-range codes.
    auto_mode = 1'b0; mode_sel = 3'd5; run(80);
    mode_sel = 3'd7; run(40);
    mode_sel = 3'd3; run(60);
    mode_sel = 3'd6; run(20);
    auto_mode = 1'b1; run(60);

    // Pause, single steps, and a held-high step.
    pause = 1'b1; run(400);
    pulse_step(); pulse_step(); pulse_step();
    @(negedge clk); step = 1'b1; run(20); step = 1'b0; run(5);
    pause = 1'b0; run(20);

    // Long prescaler period, then drop the compare below the running count.
    cfg_div = 8'd1; run(2100);
    cfg_div = 8'd2; run(900);
    cfg_div = 8'd0; run(40);

    // Enable freeze mid-animation.
    run(7);
    ena = 1'b0; step = 1'b1; run(50);
    ena = 1'b1; step = 1'b0; run(40);

    // Randomised mix of all controls.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      ena  = ($urandom_range(15) != 0);
      step = ($urandom_range(3) == 0);
      if ($urandom_range(60) == 0) pause = ~pause;
      if ($urandom_range(80) == 0) auto_mode = ~auto_mode;
      if ($urandom_range(20) == 0) mode_sel = 3'($urandom_range(7));
      if ($urandom_range(400) == 0) cfg_div = ($urandom_range(1) == 0) ? 8'd0 : 8'd1;
      if (i % 97 == 0 && cfg_div != 0) cfg_div = 8'd0;
    end
    ena = 1'b1; run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
